// File: rtl/gaussian_blur_3x3_pkg.sv
// Shared constants for the 3x3 Gaussian stage: frame defaults, kernel weights, rounding.
// Weights are powers of two, so the kernel is stored as per-tap shift amounts.
package gaussian_blur_3x3_pkg;

    localparam int DEF_IMG_WIDTH  = 800;
    localparam int DEF_IMG_HEIGHT = 600;
    localparam int SUM_W          = 12;
    localparam int ROUND          = 8;
    localparam int SHIFT          = 4;

    // [1 2 1] outer [1 2 1]: each axis contributes one doubling when on the centre line.
    function automatic int weight_shift(input int i, input int j);
        return ((i == 1) ? 1 : 0) + ((j == 1) ? 1 : 0);
    endfunction

endpackage

// File: rtl/gaussian_blur_3x3_line_buffer.sv
// One row of pixel storage: synchronous read port plus independent write port.
// Read data appears the cycle after rd_en_i; no backpressure.
module line_buffer #(
    parameter int DEPTH = 800,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gaussian_blur_3x3.sv
// 3x3 Gaussian blur, interior pixels only; 3 cycles from input pixel to dout_valid.
// Reads are throttled so queued plus in-flight pixels never exceed QDEPTH; dout holds while stalled.
module gaussian_blur_3x3
    import gaussian_blur_3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = 8,
    parameter int QDEPTH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int QAW  = $clog2(QDEPTH);
    localparam int CNTW = QAW + 1;

    logic              ign_q;
    logic              accept;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              v1_q;
    logic [CW-1:0]     c1_q;
    logic [RW-1:0]     r1_q;
    logic [DATA_W-1:0] p1_q;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] w_q [3][3];
    logic              v2_q, g2_q, l2_q;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] blur_px;
    logic [DATA_W:0]   qmem_q [QDEPTH];
    logic [DATA_W:0]   head;
    logic [QAW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]   q_count_q, q_count_d;
    logic [CNTW-1:0]   inflight_q, inflight_d;
    logic              push, pop;

    // The FIFO shares rst, so data landing the cycle after reset belongs to the discarded frame.
    assign accept     = fifo_valid & ~ign_q;
    assign fifo_rd_en = ~fifo_empty & ~rst &
                        (({1'b0, q_count_q} + {1'b0, inflight_q}) < (CNTW + 1)'(QDEPTH));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_W)) u_lb0 (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (lb0_rd),
        .wr_en_i   (v1_q),
        .wr_addr_i (c1_q),
        .wr_data_i (p1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .DW(DATA_W)) u_lb1 (
        .clk       (clk),
        .rd_en_i   (accept),
        .rd_addr_i (col_q),
        .rd_data_o (lb1_rd),
        .wr_en_i   (v1_q),
        .wr_addr_i (c1_q),
        .wr_data_i (lb0_rd)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum = sum + (SUM_W'(w_q[i][j]) << weight_shift(i, j));
    end

    assign blur_px = DATA_W'((sum + SUM_W'(ROUND)) >> SHIFT);

    assign head       = qmem_q[rd_ptr_q];
    assign dout_valid = (q_count_q != '0);
    assign dout       = dout_valid ? head[DATA_W-1:0] : '0;
    assign dout_last  = dout_valid & head[DATA_W];
    assign push       = g2_q;
    assign pop        = dout_valid & dout_ready;
    assign q_count_d  = q_count_q + CNTW'(push) - CNTW'(pop);
    // Every accepted pixel retires at stage 2, whether or not it produced an output.
    assign inflight_d = inflight_q + CNTW'(fifo_rd_en) - CNTW'(v2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ign_q      <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            g2_q       <= 1'b0;
            l2_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            q_count_q  <= '0;
            inflight_q <= '0;
        end else begin
            ign_q      <= 1'b0;
            col_q      <= col_d;
            row_q      <= row_d;
            v1_q       <= accept;
            v2_q       <= v1_q;
            g2_q       <= v1_q & (r1_q >= RW'(2)) & (c1_q >= CW'(2));
            l2_q       <= (r1_q == RW'(IMG_HEIGHT - 1)) & (c1_q == CW'(IMG_WIDTH - 1));
            if (push) wr_ptr_q <= wr_ptr_q + QAW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + QAW'(1);
            q_count_q  <= q_count_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            c1_q <= col_q;
            r1_q <= row_q;
            p1_q <= fifo_dout;
        end
        if (v1_q) begin
            for (int i = 0; i < 3; i++) begin
                w_q[i][0] <= w_q[i][1];
                w_q[i][1] <= w_q[i][2];
            end
            w_q[0][2] <= lb1_rd;
            w_q[1][2] <= lb0_rd;
            w_q[2][2] <= p1_q;
        end
        if (push) qmem_q[wr_ptr_q] <= {l2_q, blur_px};
    end

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Randomised bench for gaussian_blur_3x3 on a reduced 16x14 frame with a scoreboard model.
module tb_gaussian_blur_3x3;

    localparam int W    = 16;
    localparam int H    = 14;
    localparam int QD   = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       fifo_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       dout_ready;

    always #5 clk = ~clk;

    gaussian_blur_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8), .QDEPTH(QD)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_ready (dout_ready)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] src_q[$];
    logic [8:0] exp_q[$];
    int         img [H][W];
    int         cyc = 0;
    logic       rd_neg = 1'b0;
    logic       gap_en = 1'b0;
    logic       rdy_rand = 1'b0;
    logic       chk_rd = 1'b0;
    int         dlv_cnt = 0;
    int         valid_cyc = -1;
    int         first_out_cyc = -1;
    int         n_out = 0;
    int         n_last = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = '0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference blur of the stored frame, centred at (r,c): weight = 2^(on centre row) * 2^(on centre col).
    function automatic int model_px(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[r + dr][c + dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        return (s + 8) / 16;
    endfunction

    // kind: 0 const 100, 1 impulse 255 at (10,10), 2 ramp, 3 random, 4 replay stored frame
    task automatic load_frame(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (r == 10 && c == 10) ? 255 : 0;
                    2: img[r][c] = (c + 248) % 256;
                    3: img[r][c] = int'($urandom_range(255));
                    default: ;
                endcase
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src_q.push_back(8'(img[r][c]));
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_q.push_back({(r == H - 2 && c == W - 2), 8'(model_px(r, c))});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        fifo_valid = rd_neg;
        if (rd_neg) begin
            if (src_q.size() > 0) begin
                fifo_dout = src_q.pop_front();
                if (valid_cyc < 0 && dlv_cnt == 2 * W + 2) valid_cyc = cyc;
                dlv_cnt++;
            end else begin
                n_fail++;
                $display("FAIL read_while_empty: rd_en=1, fifo held 0 entries (cycle %0d)", cyc);
            end
        end
        fifo_empty = (src_q.size() == 0) || (gap_en && $urandom_range(99) < 30);
        dout_ready = rdy_rand ? ($urandom_range(99) < 30) : 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs still owed, required 0", exp_q.size());
            exp_q.delete();
            src_q.delete();
        end
        repeat (12) tick();
    endtask

    always @(negedge clk) begin
        rd_neg = fifo_rd_en;
        if (!rst) begin
            check("q_count_le_qdepth", int'(dut.q_count_q > QD), 0);
            if (chk_rd && !fifo_empty) check("rd_en_when_nonempty", fifo_rd_en, 1);
            if (prev_stall) begin
                check("stall_valid_held", dout_valid, 1);
                check("stall_dout_held", dout, prev_dout);
            end
            if (dout_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (dout_valid && dout_ready) begin
                n_out++;
                if (dout_last) n_last++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: dout=%0d last=%0d, none expected", dout, dout_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("dout", dout, e[7:0]);
                    check("dout_last", dout_last, e[8]);
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;
        fifo_dout  = '0;
        dout_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_dout_last", dout_last, 0);
        check("reset_dout", dout, 0);
        tick();
        rst = 1'b0;

        // Constant frame, full throughput, latency of first output
        chk_rd = 1'b1; dlv_cnt = 0; valid_cyc = -1; first_out_cyc = -1; n_out = 0; n_last = 0;
        load_frame(0);
        drain(2000);
        chk_rd = 1'b0;
        check("const_out_count", n_out, NOUT);
        check("const_last_count", n_last, 1);
        check("first_out_latency", first_out_cyc - valid_cyc, 3);

        // Impulse; pins the model against hand-computed taps
        load_frame(1);
        check("model_impulse_corner", model_px(9, 9), 16);
        check("model_impulse_edge", model_px(9, 10), 32);
        check("model_impulse_centre", model_px(10, 10), 64);
        check("model_impulse_corner2", model_px(11, 11), 16);
        check("model_impulse_outside", model_px(8, 8), 0);
        drain(2000);

        // Ramp with a 255->0 wrap at column 8
        load_frame(2);
        check("model_ramp_linear", model_px(5, 3), 251);
        check("model_ramp_wrap_lo", model_px(5, 8), 64);
        check("model_ramp_wrap_hi", model_px(5, 7), 191);
        drain(2000);

        // Random frame unstalled, then the same frame with FIFO gaps and 30% ready
        load_frame(3);
        drain(2000);
        gap_en = 1'b1; rdy_rand = 1'b1; n_out = 0;
        load_frame(4);
        drain(8000);
        gap_en = 1'b0; rdy_rand = 1'b0;
        check("stalled_out_count", n_out, NOUT);

        // Back-to-back frames A (random) then B (ramp)
        n_out = 0; n_last = 0;
        load_frame(3);
        load_frame(2);
        drain(4000);
        check("b2b_out_count", n_out, 2 * NOUT);
        check("b2b_last_count", n_last, 2);

        // Reset mid-frame at row 7, col 8, then a fresh full frame
        dlv_cnt = 0;
        load_frame(3);
        begin
            int k = 0;
            while (dlv_cnt < 7 * W + 8 && k < 2000) begin
                tick();
                k++;
            end
            check("midframe_reached", int'(dlv_cnt >= 7 * W + 8), 1);
        end
        rst = 1'b1;
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("midrst_rd_en", fifo_rd_en, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_dout_last", dout_last, 0);
        check("midrst_dout", dout, 0);
        n_out = 0; n_last = 0;
        load_frame(3);
        drain(2000);
        check("post_rst_out_count", n_out, NOUT);
        check("post_rst_last_count", n_last, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
